// File: rtl/noc_endpoint.sv
// noc_endpoint: attaches one processing element to a mesh router's local port.
// TX: encodes core messages into one-hot-addressed flits, buffers them in a
// first-word-fall-through FIFO and injects them with valid/ready.
// RX: address-checks incoming flits and hands good payloads to the core
// through a one-entry buffer; bad flits are dropped and counted.
//
// RX FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RX_EMPTY | buffer free, net_rx_ready=1, waiting for a flit
//   RX_FULL  | payload held for the core, core_rx_valid=1, router stalled
module noc_endpoint #(
    parameter logic [3:0] XCOORD     = 4'b0001,
    parameter logic [3:0] YCOORD     = 4'b0001,
    parameter int         DATA_W     = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_tx_valid,
    output logic                core_tx_ready,
    input  logic [1:0]          core_tx_dest_x,
    input  logic [1:0]          core_tx_dest_y,
    input  logic [DATA_W-1:0]   core_tx_data,
    output logic                net_tx_valid,
    input  logic                net_tx_ready,
    output logic [16+DATA_W-1:0] net_tx_flit,
    input  logic                net_rx_valid,
    output logic                net_rx_ready,
    input  logic [16+DATA_W-1:0] net_rx_flit,
    output logic                core_rx_valid,
    input  logic                core_rx_ready,
    output logic [DATA_W-1:0]   core_rx_data,
    output logic [1:0]          core_rx_src_x,
    output logic [1:0]          core_rx_src_y,
    output logic [15:0]         tx_count,
    output logic [7:0]          err_count
);

    localparam int FLIT_W = 16 + DATA_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {RX_EMPTY, RX_FULL} rx_state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Lowest set bit wins, so a malformed vector still maps deterministically.
    function automatic logic [1:0] onehot_to_bin(input logic [3:0] v);
        logic [1:0] b;
        b = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) b = 2'(i);
        end
        return b;
    endfunction

    // ---------------- TX path ----------------
    logic [FLIT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, fifo_empty, tx_push, tx_pop;
    logic [3:0]        enc_dest_x, enc_dest_y;

    assign fifo_full     = (fifo_cnt == DEPTH_CNT);
    assign fifo_empty    = (fifo_cnt == '0);
    // Held low during reset so every output reads zero while rst is high.
    assign core_tx_ready = !rst && !fifo_full;
    assign net_tx_valid  = !fifo_empty;
    assign tx_push       = core_tx_valid && core_tx_ready;
    assign tx_pop        = net_tx_valid && net_tx_ready;
    assign enc_dest_x    = 4'b0001 << core_tx_dest_x;
    assign enc_dest_y    = 4'b0001 << core_tx_dest_y;
    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign net_tx_flit   = fifo_empty ? '0 : fifo_mem[rd_ptr];

    // Write the encoded flit into the FIFO storage.
    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr] <= {enc_dest_x, enc_dest_y, XCOORD, YCOORD, core_tx_data};
    end

    // FIFO pointers, occupancy and injected-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (tx_pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                tx_count <= tx_count + 16'd1;
            end
            case ({tx_push, tx_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- RX path ----------------
    rx_state_t         rx_state_q, rx_state_d;
    logic              rx_accept, rx_good;
    logic [3:0]        rx_dest_x, rx_dest_y, rx_src_x, rx_src_y;

    assign {rx_dest_x, rx_dest_y, rx_src_x, rx_src_y} = net_rx_flit[FLIT_W-1:DATA_W];
    assign rx_good = (rx_dest_x == XCOORD) && (rx_dest_y == YCOORD)
                     && is_onehot4(rx_src_x) && is_onehot4(rx_src_y);

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state_q <= RX_EMPTY;
        else     rx_state_q <= rx_state_d;
    end

    // RX next-state and handshake outputs.
    always_comb begin
        rx_state_d    = rx_state_q;
        net_rx_ready  = 1'b0;
        core_rx_valid = 1'b0;
        rx_accept     = 1'b0;
        case (rx_state_q)
            RX_EMPTY: begin
                net_rx_ready = !rst;
                rx_accept    = net_rx_valid && !rst;
                if (rx_accept && rx_good) rx_state_d = RX_FULL;
            end
            RX_FULL: begin
                core_rx_valid = 1'b1;
                if (core_rx_ready) rx_state_d = RX_EMPTY;
            end
            default: rx_state_d = RX_EMPTY;
        endcase
    end

    // Capture good payloads and count dropped flits (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rx_data  <= '0;
            core_rx_src_x <= '0;
            core_rx_src_y <= '0;
            err_count     <= '0;
        end else if (rx_accept) begin
            if (rx_good) begin
                core_rx_data  <= net_rx_flit[DATA_W-1:0];
                core_rx_src_x <= onehot_to_bin(rx_src_x);
                core_rx_src_y <= onehot_to_bin(rx_src_y);
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_endpoint.sv
// Self-checking bench for noc_endpoint: directed scenarios plus a random
// concurrent TX/RX run, with queue scoreboards for both paths.
module tb_noc_endpoint;

    localparam logic [3:0] XC = 4'b0001;
    localparam logic [3:0] YC = 4'b0001;
    localparam int DW = 16;
    localparam int FW = 16 + DW;

    logic          clk, rst;
    logic          core_tx_valid, core_tx_ready;
    logic [1:0]    core_tx_dest_x, core_tx_dest_y;
    logic [DW-1:0] core_tx_data;
    logic          net_tx_valid, net_tx_ready;
    logic [FW-1:0] net_tx_flit;
    logic          net_rx_valid, net_rx_ready;
    logic [FW-1:0] net_rx_flit;
    logic          core_rx_valid, core_rx_ready;
    logic [DW-1:0] core_rx_data;
    logic [1:0]    core_rx_src_x, core_rx_src_y;
    logic [15:0]   tx_count;
    logic [7:0]    err_count;

    noc_endpoint #(.XCOORD(XC), .YCOORD(YC), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
        .core_tx_dest_x(core_tx_dest_x), .core_tx_dest_y(core_tx_dest_y),
        .core_tx_data(core_tx_data),
        .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready), .net_tx_flit(net_tx_flit),
        .net_rx_valid(net_rx_valid), .net_rx_ready(net_rx_ready), .net_rx_flit(net_rx_flit),
        .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
        .core_rx_data(core_rx_data), .core_rx_src_x(core_rx_src_x), .core_rx_src_y(core_rx_src_y),
        .tx_count(tx_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_tx = 0;
    int exp_err = 0;
    logic [FW-1:0] tx_exp [$];
    logic [DW+3:0] rx_exp [$];
    logic [FW-1:0] mon_f;
    logic [DW+3:0] mon_r;

    function automatic logic [FW-1:0] enc(input logic [1:0] x, input logic [1:0] y, input logic [DW-1:0] d);
        logic [3:0] one;
        one = 4'b0001;
        return {one << x, one << y, XC, YC, d};
    endfunction

    function automatic logic [1:0] bin(input logic [3:0] v);
        logic [1:0] b;
        b = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i]) b = 2'(i);
        return b;
    endfunction

    function automatic logic good_flit(input logic [FW-1:0] f);
        return (f[31:28] == XC) && (f[27:24] == YC) && $onehot(f[23:20]) && $onehot(f[19:16]);
    endfunction

    // Scoreboard monitor: samples handshakes mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (net_tx_valid && net_tx_ready) begin
                checks++;
                if (tx_exp.size() == 0) begin
                    failures++;
                    $display("FAIL tx_scoreboard: got flit %h, none expected", net_tx_flit);
                end else begin
                    mon_f = tx_exp.pop_front();
                    if (net_tx_flit !== mon_f) begin
                        failures++;
                        $display("FAIL tx_scoreboard: got %h expected %h", net_tx_flit, mon_f);
                    end
                end
                exp_tx++;
            end
            if (core_tx_valid && core_tx_ready)
                tx_exp.push_back(enc(core_tx_dest_x, core_tx_dest_y, core_tx_data));
            if (net_rx_valid && net_rx_ready) begin
                if (good_flit(net_rx_flit))
                    rx_exp.push_back({net_rx_flit[DW-1:0], bin(net_rx_flit[23:20]), bin(net_rx_flit[19:16])});
                else if (exp_err < 255)
                    exp_err++;
            end
            if (core_rx_valid && core_rx_ready) begin
                checks++;
                if (rx_exp.size() == 0) begin
                    failures++;
                    $display("FAIL rx_scoreboard: got data %h, none expected", core_rx_data);
                end else begin
                    mon_r = rx_exp.pop_front();
                    if ({core_rx_data, core_rx_src_x, core_rx_src_y} !== mon_r) begin
                        failures++;
                        $display("FAIL rx_scoreboard: got %h expected %h",
                                 {core_rx_data, core_rx_src_x, core_rx_src_y}, mon_r);
                    end
                end
            end
        end
    end

    // Offer one core message; called and returns just after a rising edge.
    task automatic send_tx(input logic [1:0] x, input logic [1:0] y, input logic [DW-1:0] d);
        int n;
        core_tx_valid = 1'b1; core_tx_dest_x = x; core_tx_dest_y = y; core_tx_data = d;
        n = 0;
        @(negedge clk);
        while (!core_tx_ready && n < 50) begin @(negedge clk); n++; end
        if (!core_tx_ready) begin
            checks++; failures++;
            $display("FAIL tx_accept_timeout: core_tx_ready=%b required 1", core_tx_ready);
        end
        @(posedge clk); #1;
        core_tx_valid = 1'b0;
    endtask

    // Present one flit from the router; called and returns just after a rising edge.
    task automatic send_rx(input logic [FW-1:0] f);
        int n;
        net_rx_valid = 1'b1; net_rx_flit = f;
        n = 0;
        @(negedge clk);
        while (!net_rx_ready && n < 50) begin @(negedge clk); n++; end
        if (!net_rx_ready) begin
            checks++; failures++;
            $display("FAIL rx_accept_timeout: net_rx_ready=%b required 1", net_rx_ready);
        end
        @(posedge clk); #1;
        net_rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({core_tx_ready, net_tx_valid, net_tx_flit, net_rx_ready, core_rx_valid, core_rx_data,
             core_rx_src_x, core_rx_src_y, tx_count, err_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got tx_rdy=%b tx_vld=%b rx_rdy=%b rx_vld=%b txc=%0d errc=%0d required all 0",
                     core_tx_ready, net_tx_valid, net_rx_ready, core_rx_valid, tx_count, err_count);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (core_tx_ready !== 1'b1 || net_rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got tx_rdy=%b rx_rdy=%b required 1 1", core_tx_ready, net_rx_ready);
        end
        checks++;
        if (net_tx_valid !== 1'b0 || core_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_valid: got tx_vld=%b rx_vld=%b required 0 0", net_tx_valid, core_rx_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tx_basic;
        net_tx_ready = 1'b1;
        send_tx(2'd2, 2'd1, 16'hBEEF);
        @(negedge clk);
        checks++;
        if (net_tx_valid !== 1'b1 || net_tx_flit !== {4'b0100, 4'b0010, XC, YC, 16'hBEEF}) begin
            failures++;
            $display("FAIL tx_basic_flit: got vld=%b flit=%h required 1 %h",
                     net_tx_valid, net_tx_flit, {4'b0100, 4'b0010, XC, YC, 16'hBEEF});
        end
        @(posedge clk); #1;
        checks++;
        if (tx_count !== 16'd1 || net_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL tx_basic_count: got count=%0d vld=%b required 1 0", tx_count, net_tx_valid);
        end
    endtask

    task automatic test_fifo_full;
        int n;
        net_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_tx(2'(i), 2'(3 - i), 16'hA000 + 16'(i));
        @(negedge clk);
        checks++;
        if (core_tx_ready !== 1'b0 || net_tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL fifo_full_flags: got tx_rdy=%b tx_vld=%b required 0 1", core_tx_ready, net_tx_valid);
        end
        @(posedge clk); #1;
        core_tx_valid = 1'b1; core_tx_dest_x = 2'd1; core_tx_dest_y = 2'd1; core_tx_data = 16'hA004;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (net_tx_valid !== 1'b1 || net_tx_flit !== enc(2'd0, 2'd3, 16'hA000) || core_tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL fifo_stall_stable: got vld=%b flit=%h rdy=%b required 1 %h 0",
                         net_tx_valid, net_tx_flit, core_tx_ready, enc(2'd0, 2'd3, 16'hA000));
            end
        end
        @(posedge clk); #1;
        net_tx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (core_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full_pop_cycle: got tx_rdy=%b required 0", core_tx_ready);
        end
        n = 0;
        while (!core_tx_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        core_tx_valid = 1'b0;
        n = 0;
        while ((tx_exp.size() != 0 || net_tx_valid) && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (tx_exp.size() != 0 || net_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL fifo_drain: got pending=%0d vld=%b required 0 0", tx_exp.size(), net_tx_valid);
        end
        checks++;
        if (tx_count !== 16'd6 || tx_count !== 16'(exp_tx)) begin
            failures++;
            $display("FAIL fifo_tx_count: got %0d required 6 (model %0d)", tx_count, exp_tx);
        end
    endtask

    task automatic test_rx_good;
        core_rx_ready = 1'b0;
        send_rx({XC, YC, 4'b1000, 4'b0100, 16'h1234});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (core_rx_valid !== 1'b1 || core_rx_data !== 16'h1234 || core_rx_src_x !== 2'd3 ||
                core_rx_src_y !== 2'd2 || net_rx_ready !== 1'b0) begin
                failures++;
                $display("FAIL rx_good_hold: got vld=%b data=%h sx=%0d sy=%0d rdy=%b required 1 1234 3 2 0",
                         core_rx_valid, core_rx_data, core_rx_src_x, core_rx_src_y, net_rx_ready);
            end
        end
        @(posedge clk); #1;
        core_rx_ready = 1'b1;
        @(posedge clk); #1;
        core_rx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (core_rx_valid !== 1'b0 || net_rx_ready !== 1'b1 || rx_exp.size() != 0) begin
            failures++;
            $display("FAIL rx_good_release: got vld=%b rdy=%b pending=%0d required 0 1 0",
                     core_rx_valid, net_rx_ready, rx_exp.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rx_errors;
        send_rx({4'b0010, YC, 4'b0001, 4'b0001, 16'h1111});
        send_rx({XC, YC, 4'b0001, 4'b0110, 16'h2222});
        @(negedge clk);
        checks++;
        if (err_count !== 8'd2 || err_count !== 8'(exp_err) || core_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rx_err_two: got errc=%0d vld=%b required 2 0", err_count, core_rx_valid);
        end
        @(posedge clk); #1;
        net_rx_valid = 1'b1;
        net_rx_flit = {XC, 4'b0100, 4'b0001, 4'b0001, 16'h3333};
        repeat (300) @(posedge clk);
        #1 net_rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_count !== 8'hFF || err_count !== 8'(exp_err) || core_rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rx_err_saturate: got errc=%h vld=%b required ff 0", err_count, core_rx_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        net_tx_ready = 1'b0;
        core_rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_tx(2'(i), 2'd0, 16'hC000 + 16'(i));
        send_rx({XC, YC, 4'b0010, 4'b0001, 16'h5555});
        @(negedge clk);
        checks++;
        if (net_tx_valid !== 1'b1 || core_rx_valid !== 1'b1 || core_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_setup: got tx_vld=%b rx_vld=%b tx_rdy=%b required 1 1 1",
                     net_tx_valid, core_rx_valid, core_tx_ready);
        end
        #2 rst = 1'b1;
        tx_exp.delete(); rx_exp.delete();
        exp_tx = 0; exp_err = 0;
        #1;
        checks++;
        if ({core_tx_ready, net_tx_valid, net_tx_flit, net_rx_ready, core_rx_valid, core_rx_data,
             core_rx_src_x, core_rx_src_y, tx_count, err_count} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got tx_vld=%b flit=%h rx_vld=%b data=%h txc=%0d errc=%0d required all 0",
                     net_tx_valid, net_tx_flit, core_rx_valid, core_rx_data, tx_count, err_count);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        net_tx_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (net_tx_valid !== 1'b0 || net_tx_flit !== '0 || core_rx_valid !== 1'b0 ||
                tx_count !== 16'd0 || core_tx_ready !== 1'b1 || net_rx_ready !== 1'b1) begin
                failures++;
                $display("FAIL midreset_after: got tx_vld=%b flit=%h rx_vld=%b txc=%0d required 0 0 0 0",
                         net_tx_valid, net_tx_flit, core_rx_valid, tx_count);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_concurrent;
        logic [3:0] one;
        int n;
        one = 4'b0001;
        for (int c = 0; c < 100; c++) begin
            core_tx_valid  = 1'($urandom_range(0, 1));
            core_tx_dest_x = 2'($urandom_range(0, 3));
            core_tx_dest_y = 2'($urandom_range(0, 3));
            core_tx_data   = 16'($urandom);
            net_tx_ready   = ($urandom_range(0, 3) != 0);
            net_rx_valid   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                net_rx_flit = {XC, YC, one << $urandom_range(0, 3), one << $urandom_range(0, 3), 16'($urandom)};
            else
                net_rx_flit = 32'($urandom);
            core_rx_ready  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        core_tx_valid = 1'b0; net_rx_valid = 1'b0;
        net_tx_ready = 1'b1; core_rx_ready = 1'b1;
        n = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0 || net_tx_valid || core_rx_valid) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (tx_exp.size() != 0 || rx_exp.size() != 0) begin
            failures++;
            $display("FAIL concurrent_drain: got tx_pending=%0d rx_pending=%0d required 0 0",
                     tx_exp.size(), rx_exp.size());
        end
        checks++;
        if (tx_count !== 16'(exp_tx) || err_count !== 8'(exp_err)) begin
            failures++;
            $display("FAIL concurrent_counts: got txc=%0d errc=%0d required %0d %0d",
                     tx_count, err_count, exp_tx, exp_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        core_tx_valid = 1'b0; core_tx_dest_x = '0; core_tx_dest_y = '0; core_tx_data = '0;
        net_tx_ready = 1'b0; net_rx_valid = 1'b0; net_rx_flit = '0; core_rx_ready = 1'b0;
        test_reset();
        test_tx_basic();
        test_fifo_full();
        test_rx_good();
        test_rx_errors();
        test_reset_mid();
        test_concurrent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
